// File: rtl/transpose_pkg.sv
// Shared types and helpers for the streaming and combinational transpose blocks.
// Flat buses carry element i at [i*DATA_WIDTH +: DATA_WIDTH].
package transpose_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_e;

  localparam logic MODE_PASS      = 1'b0;
  localparam logic MODE_TRANSPOSE = 1'b1;

  function automatic int elem_lsb(input int i, input int dw);
    return i * dw;
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// One NxN element store: row write port, row-or-column read mux, latched mode
// bit and the EMPTY/FILLING/FULL/DRAINING state of this bank.
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  localparam int CW        = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [CW-1:0]         wr_row,
  input  logic [N*DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_mode,
  input  logic                  rd_en,
  input  logic [CW-1:0]         rd_col,
  output logic [N*DATA_WIDTH-1:0] rd_data,
  output bank_state_e           state
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [DATA_WIDTH-1:0] mem_q [N][N];
  bank_state_e           state_q, state_d;
  logic                  mode_q, mode_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (wr_en) begin
      if (state_q == EMPTY) begin
        state_d = FILLING;
        mode_d  = wr_mode;
      end
      if (wr_row == LAST) state_d = FULL;
    end
    if (rd_en) begin
      if (state_q == FULL) state_d = DRAINING;
      if (rd_col == LAST) state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      mode_q  <= MODE_PASS;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Storage is deliberately not reset; stale contents are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < N; c++) begin
        mem_q[wr_row][c] <= wr_data[elem_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_rd
    assign rd_data[elem_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] =
        (mode_q == MODE_TRANSPOSE) ? mem_q[gi][rd_col] : mem_q[rd_col][gi];
  end

  assign state = state_q;

endmodule

// File: rtl/stream_transpose.sv
// Row-in / column-out streaming transpose with two ping-pong banks so one
// matrix fills while the previous one drains at one beat per cycle.
module stream_transpose
  import transpose_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_row,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_col,
  output logic                    out_last
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [CW-1:0]           wr_row_q, wr_row_d;
  logic [CW-1:0]           rd_col_q, rd_col_d;
  bank_state_e             bank_state   [2];
  logic [N*DATA_WIDTH-1:0] bank_rd_data [2];
  bank_state_e             wr_state, rd_state;
  logic                    in_fire, out_fire;

  assign wr_state  = bank_state[wr_bank_q];
  assign rd_state  = bank_state[rd_bank_q];
  // Handshakes depend only on registered state, never on the opposite side's inputs.
  assign in_ready  = !rst && (wr_state == EMPTY || wr_state == FILLING);
  assign out_valid = !rst && (rd_state == FULL || rd_state == DRAINING);
  assign out_last  = out_valid && (rd_col_q == LAST);
  assign out_col   = bank_rd_data[rd_bank_q];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    if (in_fire) begin
      if (wr_row_q == LAST) begin
        wr_row_d  = '0;
        wr_bank_d = !wr_bank_q;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end
    if (out_fire) begin
      if (rd_col_q == LAST) begin
        rd_col_d  = '0;
        rd_bank_d = !rd_bank_q;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_col_q  <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    transpose_bank #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_fire && (wr_bank_q == 1'(gi))),
      .wr_row  (wr_row_q),
      .wr_data (in_row),
      .wr_mode (in_mode),
      .rd_en   (out_fire && (rd_bank_q == 1'(gi))),
      .rd_col  (rd_col_q),
      .rd_data (bank_rd_data[gi]),
      .state   (bank_state[gi])
    );
  end

endmodule

// File: tb/tb_stream_transpose.sv
// Directed bench for stream_transpose with N=4, DATA_WIDTH=16: a vector table
// for single/pass/mode-mix matrices plus hand sequences for multi-cycle cases.
module tb_stream_transpose;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_row;
  logic            in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] out_col;
  logic            out_last;

  int total = 0;
  int bad   = 0;

  stream_transpose #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            iv;
    logic [N*DW-1:0] row;
    logic            mode;
    logic            ordy;
    logic            eov;
    logic [N*DW-1:0] ecol;
    logic            elast;
    logic            eir;
  } vec_t;

  vec_t tbl[$];

  // Row r of a matrix whose element (r,c) = base + r*4 + c.
  function automatic logic [N*DW-1:0] row_of(input int base, input int r);
    logic [N*DW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = 16'(base + r*N + c);
    return v;
  endfunction

  // Column k of the same matrix: element r = M[r][k].
  function automatic logic [N*DW-1:0] col_of(input int base, input int k);
    logic [N*DW-1:0] v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = 16'(base + r*N + k);
    return v;
  endfunction

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_beat(input string tag);
    if (out_valid && out_ready)
      $display("%s beat col=%h last=%b", tag, out_col, out_last);
  endtask

  task automatic add(input logic iv, input logic [N*DW-1:0] row, input logic mode,
                     input logic ordy, input logic eov, input logic [N*DW-1:0] ecol,
                     input logic elast, input logic eir);
    vec_t v;
    v.iv = iv; v.row = row; v.mode = mode; v.ordy = ordy;
    v.eov = eov; v.ecol = ecol; v.elast = elast; v.eir = eir;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bases3[3];
    int bp[2];
    int j;
    bases3 = '{128, 160, 192};
    bp     = '{0, 16};

    // Table: single transpose, pass-through, then transpose/pass mode mix.
    for (int k = 0; k < N; k++) add(1, row_of(0, k), 1, 1, 0, '0, 0, 1);
    for (int k = 0; k < N; k++) add(0, '0, 0, 1, 1, col_of(0, k), k == N-1, 1);
    add(0, '0, 0, 1, 0, '0, 0, 1);
    for (int k = 0; k < N; k++) add(1, row_of(0, k), 0, 1, 0, '0, 0, 1);
    for (int k = 0; k < N; k++) add(0, '0, 0, 1, 1, row_of(0, k), k == N-1, 1);
    add(0, '0, 0, 1, 0, '0, 0, 1);
    for (int k = 0; k < N; k++) add(1, row_of(32, k), 1, 1, 0, '0, 0, 1);
    for (int k = 0; k < N; k++) add(1, row_of(64, k), 0, 1, 1, col_of(32, k), k == N-1, 1);
    for (int k = 0; k < N; k++) add(0, '0, 1, 1, 1, row_of(64, k), k == N-1, 1);
    add(0, '0, 0, 1, 0, '0, 0, 1);

    rst = 1'b1; in_valid = 1'b0; in_row = '0; in_mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_row = tbl[i].row; in_mode = tbl[i].mode; out_ready = tbl[i].ordy;
      #1;
      chk("tbl_out_valid", out_valid, tbl[i].eov);
      chk("tbl_in_ready", in_ready, tbl[i].eir);
      chk("tbl_out_last", out_last, tbl[i].elast);
      if (tbl[i].eov) chk("tbl_out_col", out_col, tbl[i].ecol);
      note_beat("tbl");
    end

    // Back-to-back: 3 matrices, no gaps after the first fill.
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      in_valid = (t < 12); in_mode = 1'b1; out_ready = 1'b1;
      in_row = (t < 12) ? row_of(bases3[t/N], t%N) : '0;
      #1;
      if (t < 12) chk("b2b_in_ready", in_ready, 1);
      if (t < 4) chk("b2b_fill_valid", out_valid, 0);
      if (t >= 4) begin
        chk("b2b_out_valid", out_valid, 1);
        chk("b2b_out_col", out_col, col_of(bases3[(t-4)/N], (t-4)%N));
        chk("b2b_out_last", out_last, ((t-4)%N) == N-1);
      end
      note_beat("b2b");
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b_idle_valid", out_valid, 0);

    // Backpressure: two matrices load with out_ready low, then drain in order.
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      in_valid = (t < 10); in_mode = 1'b1; out_ready = (t >= 10);
      in_row = (t < 8) ? row_of(bp[t/N], t%N) : 64'hdead_beef_dead_beef;
      #1;
      chk("bp_in_ready", in_ready, (t < 8) || (t >= 14));
      if (t < 4) chk("bp_fill_valid", out_valid, 0);
      if (t >= 4) begin
        j = (t < 10) ? 0 : t - 10;
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_col", out_col, col_of(bp[j/N], j%N));
        chk("bp_out_last", out_last, (t >= 10) && ((j%N) == N-1));
      end
      note_beat("bp");
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_idle_valid", out_valid, 0);

    // Mid-matrix reset: partial matrix A discarded, B emerges transposed.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = 1'b1; out_ready = 1'b1; in_row = row_of(48, t);
      #1;
      chk("mr_a_in_ready", in_ready, 1);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("mr_rst_in_ready", in_ready, 0);
    chk("mr_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_post_in_ready", in_ready, 1);
    chk("mr_post_out_valid", out_valid, 0);
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      in_valid = (t < 4); in_mode = 1'b1; out_ready = 1'b1;
      in_row = (t < 4) ? row_of(80, t) : '0;
      #1;
      if (t < 4) chk("mr_b_fill_valid", out_valid, 0);
      if (t >= 4 && t < 8) begin
        chk("mr_b_out_valid", out_valid, 1);
        chk("mr_b_out_col", out_col, col_of(80, t-4));
        chk("mr_b_out_last", out_last, (t-4) == N-1);
      end
      if (t == 8) chk("mr_b_idle_valid", out_valid, 0);
      note_beat("mr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
